key_debounce: RTL and testbench

//   Board push-button input conditioner; the input-side companion of the 1 s LED blinker.
//   - Synchronises a raw mechanical key on clk.
//   - Debounces it against a free-running 1 us / 1 ms tick chain derived from clk.
//   - Emits a debounced level plus one-cycle press/release pulses for downstream control logic.

---
 rtl/key_debounce.sv | 190 +++++++++++++++++++
 tb/tb_key_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Push-button input conditioner for the board. It brings a raw, active-low
//   mechanical key into the clk domain and debounces it against a 1 us / 1 ms
//   tick chain that runs freely from clk. It drives a debounced level plus
//   one-cycle press and release pulses for downstream control logic.
//
// Optional feature (macro KEY_LONG_PRESS_EN):
//   When the macro is defined, key_long pulses once after the key has been
//   held for LONG_PRESS_MS ms ticks. When it is undefined, key_long is tied
//   to 0.
//
// Ports
//   clk          in   board clock
//   reset        in   asynchronous reset, active low
//   key_in       in   raw key, asynchronous, 0 = pressed
//   key_state    out  debounced level, 1 = pressed
//   key_press    out  one-cycle pulse when a press is accepted
//   key_release  out  one-cycle pulse when a release is accepted
//   key_long     out  one-cycle pulse on a long hold
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int CLK_PER_US    = 50,
    parameter int US_PER_MS     = 1000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CLK_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);

    // Reject parameter sets the debounce counter cannot represent.
    if (DEBOUNCE_MS < 1 || LONG_PRESS_MS < 1) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_MS and LONG_PRESS_MS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             k_pr;
    logic [CLK_W-1:0] clk_cnt;
    logic [US_W-1:0]  us_cnt;
    logic             us_tick;
    logic             ms_tick;
    state_t           state;
    state_t           state_next;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_next;
    logic             press_next;
    logic             release_next;
    logic             level_next;

    // Two-flop synchroniser. It resets to the released level (1) so that the
    // FSM does not see a phantom press coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign k_pr = ~sync2;

    // The timebase runs independently of key activity. This is why the
    // acceptance latency varies by up to one ms period.
    assign us_tick = (clk_cnt == CLK_W'(CLK_PER_US - 1));
    assign ms_tick = us_tick && (us_cnt == US_W'(US_PER_MS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            clk_cnt <= us_tick ? '0 : clk_cnt + CLK_W'(1);
            if (us_tick) begin
                us_cnt <= ms_tick ? '0 : us_cnt + US_W'(1);
            end
        end
    end

    // Next-state logic. A debounce window completes on the ms_tick that
    // would bring db_cnt to DEBOUNCE_MS. The registered outputs then show
    // the new level and the pulse in the very next cycle.
    always_comb begin
        state_next   = state;
        db_cnt_next  = db_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (k_pr) state_next = PRESS_DB;
            end
            PRESS_DB: begin
                if (!k_pr) begin
                    state_next = IDLE;
                end else if (ms_tick) begin
                    if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                        state_next = HELD;
                        press_next = 1'b1;
                    end else begin
                        db_cnt_next = db_cnt + DB_W'(1);
                    end
                end
            end
            HELD: begin
                if (!k_pr) state_next = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (k_pr) begin
                    state_next = HELD;
                end else if (ms_tick) begin
                    if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                        state_next   = IDLE;
                        release_next = 1'b1;
                    end else begin
                        db_cnt_next = db_cnt + DB_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) db_cnt_next = '0;
        level_next = (state_next == HELD) || (state_next == RELEASE_DB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            db_cnt      <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_next;
            db_cnt      <= db_cnt_next;
            key_state   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_next;

    // hold_cnt restarts only on a fresh accepted press. A bounce through
    // RELEASE_DB keeps the count. Saturation limits key_long to one pulse
    // per press.
    assign long_next = (state == HELD) && ms_tick &&
                       (hold_cnt == HOLD_W'(LONG_PRESS_MS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= long_next;
            if (state == PRESS_DB && state_next == HELD) begin
                hold_cnt <= '0;
            end else if (state == HELD && ms_tick &&
                         hold_cnt != HOLD_W'(LONG_PRESS_MS)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//   Directed bench for key_debounce with small timebase parameters. A ms
//   tick occurs every 10 clk and 3 ticks are needed to accept a change.
//   The expected latency windows are worked out by hand from those numbers.
//   The long-press step depends on KEY_LONG_PRESS_EN.
// ---------------------------------------------------------------------------
module tb_key_debounce;

    logic clk = 1'b0;
    logic reset;
    logic key_in;
    logic key_state;
    logic key_press;
    logic key_release;
    logic key_long;

    int n_checks = 0;
    int n_fail   = 0;
    int press_cnt   = 0;
    int release_cnt = 0;
    int long_cnt    = 0;

    key_debounce #(
        .CLK_PER_US   (2),
        .US_PER_MS    (5),
        .DEBOUNCE_MS  (3),
        .LONG_PRESS_MS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle. A cycle with both pulses high is
    // always an error.
    always @(negedge clk) begin
        if (key_press)   press_cnt++;
        if (key_release) release_cnt++;
        if (key_long)    long_cnt++;
        if (key_press && key_release) begin
            n_fail++;
            $error("[TB] FAIL pulse_overlap: observed press=1 release=1, expected not both");
        end
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        n_checks++;
        assert (observed >= lo && observed <= hi) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Counts posedges from now until the selected pulse is seen. Returns -1
    // if it is not seen within the bound.
    task automatic wait_pulse(input int which, input int bound, output int lat);
        bit found = 1'b0;
        lat = 0;
        while (!found && lat < bound) begin
            @(posedge clk);
            #1;
            lat++;
            case (which)
                0:       found = key_press;
                1:       found = key_release;
                default: found = key_long;
            endcase
        end
        if (!found) lat = -1;
    endtask

    initial begin
        int lat;
        int p0;
        int r0;
        int l0;

        // 1. Reset state and quiet idle.
        reset  = 1'b0;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_state",   key_state,   0);
        check_output("rst_press",   key_press,   0);
        check_output("rst_release", key_release, 0);
        check_output("rst_long",    key_long,    0);
        key_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check_output("idle_press_cnt",   press_cnt,   0);
        check_output("idle_release_cnt", release_cnt, 0);
        check_output("idle_state",       key_state,   0);

        // 2. Clean press.
        p0 = press_cnt;
        key_in = 1'b0;
        wait_pulse(0, 60, lat);
        check_range("press_latency", lat, 23, 33);
        check_output("press_level", key_state, 1);
        repeat (150) @(negedge clk);
        check_output("press_once",  press_cnt - p0, 1);
        check_output("press_held",  key_state,      1);
        check_output("press_no_rel", release_cnt,   0);

        // Clean release.
        r0 = release_cnt;
        key_in = 1'b1;
        wait_pulse(1, 60, lat);
        check_range("release_latency", lat, 23, 33);
        check_output("release_level", key_state, 0);
        repeat (100) @(negedge clk);
        check_output("release_once", release_cnt - r0, 1);

        // 3. Bouncing press: toggle every 3 clk for 30 clk, then settle low.
        p0 = press_cnt;
        for (int i = 0; i < 10; i++) begin
            key_in = ~key_in;
            repeat (3) @(negedge clk);
        end
        key_in = 1'b0;
        repeat (200) @(negedge clk);
        check_output("bounce_press_once", press_cnt - p0, 1);
        check_output("bounce_level",      key_state,      1);

        // 4. High glitch while held is rejected.
        r0 = release_cnt;
        key_in = 1'b1;
        repeat (5) @(negedge clk);
        key_in = 1'b0;
        repeat (100) @(negedge clk);
        check_output("hi_glitch_no_rel", release_cnt - r0, 0);
        check_output("hi_glitch_level",  key_state,        1);

        key_in = 1'b1;
        repeat (200) @(negedge clk);
        check_output("bounce_release_once", release_cnt - r0, 1);
        check_output("bounce_release_lvl",  key_state,        0);

        // Low glitch while idle is rejected.
        p0 = press_cnt;
        key_in = 1'b0;
        repeat (8) @(negedge clk);
        key_in = 1'b1;
        repeat (100) @(negedge clk);
        check_output("lo_glitch_no_press", press_cnt - p0, 0);
        check_output("lo_glitch_level",    key_state,      0);

        // 5a. Reset while held clears the level without a clock edge.
        r0 = release_cnt;
        key_in = 1'b0;
        repeat (200) @(negedge clk);
        check_output("pre_reset_level", key_state, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("async_reset_level", key_state, 0);
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check_output("reset_held_no_rel", release_cnt - r0, 0);

        // 5b. Reset in PRESS_DB: no pending press may appear afterwards.
        p0 = press_cnt;
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("reset_db_press", key_press, 0);
        check_output("reset_db_level", key_state, 0);
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check_output("reset_db_no_press", press_cnt - p0, 0);
        check_output("reset_db_no_rel",   release_cnt - r0, 0);

        // 6. Long press.
`ifdef KEY_LONG_PRESS_EN
        l0 = long_cnt;
        key_in = 1'b0;
        wait_pulse(0, 60, lat);
        check_range("long_press_latency", lat, 23, 33);
        wait_pulse(2, 120, lat);
        check_range("long_latency", lat, 71, 81);
        repeat (200) @(negedge clk);
        check_output("long_once", long_cnt - l0, 1);
`else
        l0 = long_cnt;
        key_in = 1'b0;
        repeat (300) @(negedge clk);
        check_output("long_tied_cnt", long_cnt, 0);
        check_output("long_tied_lvl", key_long, 0);
        check_output("long_hold_lvl", key_state, 1);
        check_output("long_tied_delta", long_cnt - l0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
